// File: rtl/ddr_rd_arbiter.sv
// Arbitrates the single DDR read-burst port between the ISA loader and the data loader.
// Build option ARB_RR_EN selects round-robin tie-break; otherwise ISA has fixed priority.
module ddr_rd_arbiter #(
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned DDR_DATA_WIDTH = 32,
  parameter int unsigned ISA_WIDTH      = 30,
  parameter int unsigned LEN_WIDTH      = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      isa_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0] isa_rd_addr,
  input  logic [LEN_WIDTH-1:0]      isa_rd_len,
  output logic [ISA_WIDTH-1:0]      isa_rd_data,
  output logic                      isa_rd_valid,
  output logic [LEN_WIDTH-1:0]      isa_rd_cnt,
  output logic                      isa_rd_done,
  input  logic                      dat_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0] dat_rd_addr,
  input  logic [LEN_WIDTH-1:0]      dat_rd_len,
  output logic [DDR_DATA_WIDTH-1:0] dat_rd_data,
  output logic                      dat_rd_valid,
  output logic [LEN_WIDTH-1:0]      dat_rd_cnt,
  output logic                      dat_rd_done,
  output logic                      rd_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [LEN_WIDTH-1:0]      rd_burst_len,
  input  logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
  input  logic                      rd_burst_data_valid,
  input  logic                      rd_burst_finish,
  output logic                      grant_isa,
  output logic [1:0]                st_cur_arb
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic                 last_isa;
  logic                 pick_isa;
  logic                 any_req;
  logic [LEN_WIDTH-1:0] win_len;
  logic                 isa_beat;
  logic                 dat_beat;

  // Winner selection and next-state logic
  always_comb begin
    state_nxt = state;
    any_req   = isa_rd_req | dat_rd_req;
`ifdef ARB_RR_EN
    pick_isa  = isa_rd_req & (~dat_rd_req | ~last_isa);
`else
    pick_isa  = isa_rd_req;
`endif
    win_len   = pick_isa ? isa_rd_len : dat_rd_len;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = (win_len == '0) ? ST_DONE : ST_BURST;
      ST_BURST: if (rd_burst_finish) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A beat is accepted only while the granted side still owes beats
  always_comb begin
    isa_beat     = (state == ST_BURST) &  grant_isa & rd_burst_data_valid & (isa_rd_cnt < rd_burst_len);
    dat_beat     = (state == ST_BURST) & ~grant_isa & rd_burst_data_valid & (dat_rd_cnt < rd_burst_len);
    isa_rd_valid = isa_beat;
    dat_rd_valid = dat_beat;
    isa_rd_data  = isa_beat ? rd_burst_data[ISA_WIDTH-1:0] : '0;
    dat_rd_data  = dat_beat ? rd_burst_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      last_isa      <= 1'b0;
      grant_isa     <= 1'b0;
      rd_burst_req  <= 1'b0;
      rd_burst_addr <= '0;
      rd_burst_len  <= '0;
      isa_rd_cnt    <= '0;
      dat_rd_cnt    <= '0;
      isa_rd_done   <= 1'b0;
      dat_rd_done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      isa_rd_done <= 1'b0;
      dat_rd_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_isa     <= pick_isa;
            last_isa      <= pick_isa;
            rd_burst_addr <= pick_isa ? isa_rd_addr : dat_rd_addr;
            rd_burst_len  <= win_len;
            rd_burst_req  <= (win_len != '0);
            if (pick_isa) isa_rd_cnt <= '0;
            else          dat_rd_cnt <= '0;
            // Zero-length burst completes without touching DDR
            if (win_len == '0) begin
              isa_rd_done <= pick_isa;
              dat_rd_done <= ~pick_isa;
            end
          end
        end
        ST_BURST: begin
          if (isa_beat) isa_rd_cnt <= isa_rd_cnt + LEN_WIDTH'(1);
          if (dat_beat) dat_rd_cnt <= dat_rd_cnt + LEN_WIDTH'(1);
          if (rd_burst_finish) begin
            rd_burst_req <= 1'b0;
            isa_rd_done  <= grant_isa;
            dat_rd_done  <= ~grant_isa;
          end
        end
        ST_DONE: grant_isa <= 1'b0;
        default: grant_isa <= 1'b0;
      endcase
    end
  end

  assign st_cur_arb = state;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed bench for ddr_rd_arbiter; expectations follow ARB_RR_EN if defined.
module tb_ddr_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        isa_rd_req;
  logic [27:0] isa_rd_addr;
  logic [9:0]  isa_rd_len;
  logic [29:0] isa_rd_data;
  logic        isa_rd_valid;
  logic [9:0]  isa_rd_cnt;
  logic        isa_rd_done;
  logic        dat_rd_req;
  logic [27:0] dat_rd_addr;
  logic [9:0]  dat_rd_len;
  logic [31:0] dat_rd_data;
  logic        dat_rd_valid;
  logic [9:0]  dat_rd_cnt;
  logic        dat_rd_done;
  logic        rd_burst_req;
  logic [27:0] rd_burst_addr;
  logic [9:0]  rd_burst_len;
  logic [31:0] rd_burst_data;
  logic        rd_burst_data_valid;
  logic        rd_burst_finish;
  logic        grant_isa;
  logic [1:0]  st_cur_arb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .isa_rd_req(isa_rd_req), .isa_rd_addr(isa_rd_addr), .isa_rd_len(isa_rd_len),
    .isa_rd_data(isa_rd_data), .isa_rd_valid(isa_rd_valid), .isa_rd_cnt(isa_rd_cnt),
    .isa_rd_done(isa_rd_done),
    .dat_rd_req(dat_rd_req), .dat_rd_addr(dat_rd_addr), .dat_rd_len(dat_rd_len),
    .dat_rd_data(dat_rd_data), .dat_rd_valid(dat_rd_valid), .dat_rd_cnt(dat_rd_cnt),
    .dat_rd_done(dat_rd_done),
    .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
    .rd_burst_data(rd_burst_data), .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_finish(rd_burst_finish),
    .grant_isa(grant_isa), .st_cur_arb(st_cur_arb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic fin);
    rd_burst_data       = d;
    rd_burst_data_valid = 1'b1;
    rd_burst_finish     = fin;
    #1;
  endtask

  task automatic bus_idle();
    rd_burst_data       = '0;
    rd_burst_data_valid = 1'b0;
    rd_burst_finish     = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    isa_rd_req = 1'b0; isa_rd_addr = '0; isa_rd_len = '0;
    dat_rd_req = 1'b0; dat_rd_addr = '0; dat_rd_len = '0;
    bus_idle();
    step(); step();
    rst = 1'b0;
    chk("rst_state", 32'(st_cur_arb), 32'd0);
    chk("rst_req", 32'(rd_burst_req), 32'd0);
    chk("rst_grant", 32'(grant_isa), 32'd0);
    chk("rst_isa_cnt", 32'(isa_rd_cnt), 32'd0);
    chk("rst_dat_done", 32'(dat_rd_done), 32'd0);

    // ISA-only burst of 4, with a mid-burst address change
    isa_rd_req = 1'b1; isa_rd_addr = 28'h80; isa_rd_len = 10'd4;
    step();
    chk("t1_state", 32'(st_cur_arb), 32'd1);
    chk("t1_req", 32'(rd_burst_req), 32'd1);
    chk("t1_grant", 32'(grant_isa), 32'd1);
    chk("t1_addr", 32'(rd_burst_addr), 32'h80);
    chk("t1_len", 32'(rd_burst_len), 32'd4);
    for (int i = 0; i < 4; i++) begin
      d = 32'hFFFF_FFF0 + 32'(i);
      beat(d, i == 3);
      chk("t1_valid", 32'(isa_rd_valid), 32'd1);
      chk("t1_data", 32'(isa_rd_data), d & 32'h3FFF_FFFF);
      chk("t1_dvalid", 32'(dat_rd_valid), 32'd0);
      chk("t1_cnt", 32'(isa_rd_cnt), 32'(i));
      if (i == 1) isa_rd_addr = 28'h100;
      step();
      chk("t6_addr_hold", 32'(rd_burst_addr), 32'h80);
    end
    bus_idle();
    chk("t1_done_state", 32'(st_cur_arb), 32'd2);
    chk("t1_done", 32'(isa_rd_done), 32'd1);
    chk("t1_req_low", 32'(rd_burst_req), 32'd0);
    chk("t1_cnt_final", 32'(isa_rd_cnt), 32'd4);
    isa_rd_req = 1'b0;
    step();
    chk("t1_idle", 32'(st_cur_arb), 32'd0);
    chk("t1_done_pulse", 32'(isa_rd_done), 32'd0);
    chk("t1_grant_clr", 32'(grant_isa), 32'd0);
    chk("t1_cnt_hold", 32'(isa_rd_cnt), 32'd4);

    // Data burst of 2 with an extra beat from DDR
    dat_rd_req = 1'b1; dat_rd_addr = 28'h200; dat_rd_len = 10'd2;
    step();
    chk("t3_grant", 32'(grant_isa), 32'd0);
    chk("t3_addr", 32'(rd_burst_addr), 32'h200);
    for (int i = 0; i < 3; i++) begin
      d = 32'h1234_5600 + 32'(i);
      beat(d, i == 2);
      chk("t3_valid", 32'(dat_rd_valid), (i < 2) ? 32'd1 : 32'd0);
      chk("t3_data", dat_rd_data, (i < 2) ? d : 32'd0);
      chk("t3_ivalid", 32'(isa_rd_valid), 32'd0);
      step();
    end
    bus_idle();
    chk("t3_cnt", 32'(dat_rd_cnt), 32'd2);
    chk("t3_done", 32'(dat_rd_done), 32'd1);
    chk("t3_isa_done", 32'(isa_rd_done), 32'd0);
    dat_rd_req = 1'b0;
    step();
    chk("t3_idle", 32'(st_cur_arb), 32'd0);

    // Zero-length ISA request
    isa_rd_req = 1'b1; isa_rd_len = 10'd0;
    step();
    chk("t4_state", 32'(st_cur_arb), 32'd2);
    chk("t4_req", 32'(rd_burst_req), 32'd0);
    chk("t4_done", 32'(isa_rd_done), 32'd1);
    chk("t4_cnt", 32'(isa_rd_cnt), 32'd0);
    isa_rd_req = 1'b0;
    step();
    chk("t4_idle", 32'(st_cur_arb), 32'd0);
    chk("t4_done_clr", 32'(isa_rd_done), 32'd0);

    // Simultaneous requests straight after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    isa_rd_req = 1'b1; isa_rd_addr = 28'h10; isa_rd_len = 10'd1;
    dat_rd_req = 1'b1; dat_rd_addr = 28'h20; dat_rd_len = 10'd1;
    step();
    chk("t2_first_grant", 32'(grant_isa), 32'd1);
    chk("t2_first_addr", 32'(rd_burst_addr), 32'h10);
    beat(32'hAAAA_0001, 1'b1);
    step();
    bus_idle();
    chk("t2_first_done", 32'(isa_rd_done), 32'd1);
    step();
    chk("t2_idle", 32'(st_cur_arb), 32'd0);
    step();
`ifdef ARB_RR_EN
    chk("t2_second_grant", 32'(grant_isa), 32'd0);
    chk("t2_second_addr", 32'(rd_burst_addr), 32'h20);
`else
    chk("t2_second_grant", 32'(grant_isa), 32'd1);
    chk("t2_second_addr", 32'(rd_burst_addr), 32'h10);
`endif
    beat(32'hBBBB_0002, 1'b1);
    step();
    bus_idle();
`ifdef ARB_RR_EN
    chk("t2_second_done", 32'(dat_rd_done), 32'd1);
`else
    chk("t2_second_done", 32'(isa_rd_done), 32'd1);
`endif
    isa_rd_req = 1'b0; dat_rd_req = 1'b0;
    step();

    // Reset after 2 of 8 beats, then a clean re-request
    isa_rd_req = 1'b1; isa_rd_addr = 28'h300; isa_rd_len = 10'd8;
    step();
    for (int i = 0; i < 2; i++) begin
      beat(32'h5555_0000 + 32'(i), 1'b0);
      step();
    end
    bus_idle();
    chk("t5_cnt_mid", 32'(isa_rd_cnt), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_state", 32'(st_cur_arb), 32'd0);
    chk("t5_req", 32'(rd_burst_req), 32'd0);
    chk("t5_grant", 32'(grant_isa), 32'd0);
    chk("t5_cnt", 32'(isa_rd_cnt), 32'd0);
    chk("t5_no_done", 32'(isa_rd_done), 32'd0);
    chk("t5_addr", 32'(rd_burst_addr), 32'd0);
    isa_rd_len = 10'd2;
    step();
    chk("t5_rereq", 32'(rd_burst_req), 32'd1);
    chk("t5_recnt", 32'(isa_rd_cnt), 32'd0);
    beat(32'h6666_0000, 1'b0);
    step();
    beat(32'h6666_0001, 1'b1);
    step();
    bus_idle();
    chk("t5_done", 32'(isa_rd_done), 32'd1);
    chk("t5_cnt_final", 32'(isa_rd_cnt), 32'd2);
    isa_rd_req = 1'b0;
    step();
    chk("t5_idle", 32'(st_cur_arb), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
